// File: rtl/boot_pkg.sv
// Shared types and defaults for the instruction-memory boot loader.
// Imported by the loader top and its hold counter.
package boot_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RELEASE,
    RUN
  } boot_state_e;

  localparam int BOOT_HOLD_DEFAULT = 4;

endpackage

// File: rtl/boot_hold_counter.sv
// Loadable down-counter with zero flag.
// Times how long the core stays held after the final imem write.
module boot_hold_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  input  logic         en_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= val_i;
    end else if (en_i && cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/imem_boot_loader.sv
// Sequenced imem program loader: holds the core in reset, writes a
// checked word stream into imem, then releases the core.
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int IAW         = 9,
  parameter int DW          = 32,
  parameter int HOLD_CYCLES = BOOT_HOLD_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [IAW-1:0] cfg_base,
  input  logic [IAW:0]   cfg_len,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic [DW-1:0]  s_data,
  output logic           imem_we,
  output logic [IAW-1:0] imem_addr,
  output logic [DW-1:0]  imem_wdata,
  output logic           core_rst_n,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [DW-1:0]  checksum
);

  localparam int HW = $clog2(HOLD_CYCLES) + 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [IAW+1:0] LIMIT = {2'b01, {IAW{1'b0}}};

  boot_state_e    state_q;
  logic [IAW-1:0] ptr_q;
  logic [IAW:0]   rem_q;
  logic           we_q;
  logic [IAW-1:0] addr_q;
  logic [DW-1:0]  wdata_q;
  logic           core_rst_n_q;
  logic           busy_q;
  logic           done_q;
  logic           err_q;
  logic [DW-1:0]  sum_q;

  logic           acc;
  logic           last;
  logic           can_start;
  logic [IAW+1:0] span;
  logic           range_bad;
  logic           go_zero;
  logic           hold_load;
  logic           hold_zero;

  assign s_ready   = (state_q == LOAD) && (rem_q != '0);
  assign acc       = s_valid && s_ready;
  assign last      = acc && (rem_q == (IAW+1)'(1));
  assign can_start = start && (state_q == IDLE || state_q == RUN);
  // Range check is done two bits wide so base + len can never wrap.
  assign span      = {2'b00, cfg_base} + {1'b0, cfg_len};
  assign range_bad = span > LIMIT;
  assign go_zero   = can_start && !range_bad && (cfg_len == '0);
  assign hold_load = last || go_zero;

  boot_hold_counter #(
    .W (HW)
  ) u_hold (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (hold_load),
    .val_i  (HOLD_LOAD),
    .en_i   (state_q == RELEASE),
    .zero_o (hold_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      rem_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      core_rst_n_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      sum_q        <= '0;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        IDLE, RUN: begin
          if (can_start) begin
            if (range_bad) begin
              err_q <= 1'b1;
            end else begin
              ptr_q        <= cfg_base;
              rem_q        <= cfg_len;
              sum_q        <= '0;
              core_rst_n_q <= 1'b0;
              busy_q       <= 1'b1;
              state_q      <= (cfg_len == '0) ? RELEASE : LOAD;
            end
          end
        end
        LOAD: begin
          if (acc) begin
            we_q    <= 1'b1;
            addr_q  <= ptr_q;
            wdata_q <= s_data;
            sum_q   <= sum_q + s_data;
            ptr_q   <= ptr_q + 1'b1;
            rem_q   <= rem_q - 1'b1;
            if (last) state_q <= RELEASE;
          end
        end
        RELEASE: begin
          if (hold_zero) begin
            state_q      <= RUN;
            core_rst_n_q <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign core_rst_n = core_rst_n_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign checksum   = sum_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_imem_boot_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [8:0]  cfg_base;
  logic [9:0]  cfg_len;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        imem_we;
  logic [8:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        core_rst_n;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] checksum;

  int ncmp = 0;
  int nfail = 0;

  imem_boot_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cfg_base   (cfg_base),
    .cfg_len    (cfg_len),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst_n (core_rst_n),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .checksum   (checksum)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".s_ready"}, 64'(s_ready), 0);
    chk({tag, ".we"}, 64'(imem_we), 0);
    chk({tag, ".addr"}, 64'(imem_addr), 0);
    chk({tag, ".wdata"}, 64'(imem_wdata), 0);
    chk({tag, ".core_rst_n"}, 64'(core_rst_n), 0);
    chk({tag, ".busy"}, 64'(busy), 0);
    chk({tag, ".done"}, 64'(done), 0);
    chk({tag, ".err"}, 64'(err), 0);
    chk({tag, ".checksum"}, 64'(checksum), 0);
  endtask

  // Called in the first RELEASE cycle; RUN is entered 4 cycles later.
  task automatic chk_release(input string tag);
    for (int i = 0; i < 3; i++) begin
      step();
      chk({tag, ".hold_rst"}, 64'(core_rst_n), 0);
      chk({tag, ".hold_done"}, 64'(done), 0);
      chk({tag, ".hold_we"}, 64'(imem_we), 0);
    end
    step();
    chk({tag, ".run_rst"}, 64'(core_rst_n), 1);
    chk({tag, ".run_done"}, 64'(done), 1);
    chk({tag, ".run_busy"}, 64'(busy), 0);
    step();
    chk({tag, ".done_pulse"}, 64'(done), 0);
    chk({tag, ".still_run"}, 64'(core_rst_n), 1);
  endtask

  task automatic do_start(input logic [8:0] b, input logic [9:0] l);
    start = 1'b1;
    cfg_base = b;
    cfg_len = l;
    step();
    start = 1'b0;
  endtask

  int pat[7] = '{1, 0, 0, 1, 1, 0, 1};
  logic [31:0] bd[4] = '{32'hFFFF_FFFF, 32'h1, 32'h2, 32'h3};

  initial begin
    int k;
    rst_n = 1'b0;
    start = 1'b0;
    cfg_base = '0;
    cfg_len = '0;
    s_valid = 1'b0;
    s_data = '0;
    step();
    step();
    chk_reset_vals("reset");
    rst_n = 1'b1;
    step();
    chk("idle_rst", 64'(core_rst_n), 0);

    // Basic three-word load
    do_start(9'h010, 10'd3);
    chk("basic.busy", 64'(busy), 1);
    chk("basic.ready", 64'(s_ready), 1);
    chk("basic.we0", 64'(imem_we), 0);
    s_valid = 1'b1;
    s_data = 32'h0000_0013;
    step();
    chk("basic.w0", 64'(imem_we), 1);
    chk("basic.a0", 64'(imem_addr), 64'h010);
    chk("basic.d0", 64'(imem_wdata), 64'h0000_0013);
    s_data = 32'h0010_0093;
    step();
    chk("basic.w1", 64'(imem_we), 1);
    chk("basic.a1", 64'(imem_addr), 64'h011);
    chk("basic.d1", 64'(imem_wdata), 64'h0010_0093);
    s_data = 32'h0020_8113;
    step();
    s_valid = 1'b0;
    chk("basic.w2", 64'(imem_we), 1);
    chk("basic.a2", 64'(imem_addr), 64'h012);
    chk("basic.d2", 64'(imem_wdata), 64'h0020_8113);
    chk("basic.ready_off", 64'(s_ready), 0);
    chk("basic.sum", 64'(checksum), 64'h0030_81B9);
    chk_release("basic");

    // Backpressure with wrapping checksum
    do_start(9'h000, 10'd4);
    chk("bp.rst_low", 64'(core_rst_n), 0);
    chk("bp.busy", 64'(busy), 1);
    chk("bp.sum_clr", 64'(checksum), 0);
    k = 0;
    for (int i = 0; i < 7; i++) begin
      s_valid = pat[i][0];
      s_data = (k < 4) ? bd[k] : 32'h0;
      step();
      if (pat[i] == 1) begin
        chk("bp.we", 64'(imem_we), 1);
        chk("bp.addr", 64'(imem_addr), 64'(k));
        chk("bp.data", 64'(imem_wdata), 64'(bd[k]));
        k++;
      end else begin
        chk("bp.gap_we", 64'(imem_we), 0);
      end
    end
    s_valid = 1'b0;
    chk("bp.ready_off", 64'(s_ready), 0);
    chk("bp.sum", 64'(checksum), 64'h5);
    chk_release("bp");

    // Zero length goes straight to RELEASE
    do_start(9'h005, 10'd0);
    chk("zero.busy", 64'(busy), 1);
    chk("zero.rst_low", 64'(core_rst_n), 0);
    chk("zero.ready", 64'(s_ready), 0);
    chk("zero.sum", 64'(checksum), 0);
    chk_release("zero");

    // Out of range start from RUN
    do_start(9'h1FF, 10'd2);
    chk("range.err", 64'(err), 1);
    chk("range.busy", 64'(busy), 0);
    chk("range.rst", 64'(core_rst_n), 1);
    chk("range.ready", 64'(s_ready), 0);
    step();
    chk("range.err_pulse", 64'(err), 0);
    chk("range.we", 64'(imem_we), 0);

    // Last word of imem is a legal single-word load
    do_start(9'h1FF, 10'd1);
    chk("edge.err", 64'(err), 0);
    chk("edge.busy", 64'(busy), 1);
    s_valid = 1'b1;
    s_data = 32'hDEAD_BEEF;
    step();
    s_valid = 1'b0;
    chk("edge.we", 64'(imem_we), 1);
    chk("edge.addr", 64'(imem_addr), 64'h1FF);
    chk("edge.ready", 64'(s_ready), 0);
    chk_release("edge");

    // Reload from RUN; start during LOAD is ignored
    do_start(9'h020, 10'd2);
    chk("reload.rst_low", 64'(core_rst_n), 0);
    chk("reload.busy", 64'(busy), 1);
    chk("reload.sum_clr", 64'(checksum), 0);
    start = 1'b1;
    cfg_base = 9'h1FF;
    cfg_len = 10'd2;
    s_valid = 1'b1;
    s_data = 32'h7;
    step();
    start = 1'b0;
    chk("reload.no_err", 64'(err), 0);
    chk("reload.a0", 64'(imem_addr), 64'h020);
    s_data = 32'h8;
    step();
    s_valid = 1'b0;
    chk("reload.a1", 64'(imem_addr), 64'h021);
    chk("reload.sum", 64'(checksum), 64'hF);
    chk_release("reload");

    // Asynchronous reset in the middle of a load
    do_start(9'h040, 10'd5);
    s_valid = 1'b1;
    s_data = 32'h11;
    step();
    s_data = 32'h22;
    step();
    chk("mid.w1", 64'(imem_addr), 64'h041);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("mid_reset");
    step();
    rst_n = 1'b1;
    step();
    chk("mid.ready_after", 64'(s_ready), 0);
    chk("mid.rst_held", 64'(core_rst_n), 0);
    chk("mid.we_after", 64'(imem_we), 0);
    s_valid = 1'b0;
    do_start(9'h030, 10'd1);
    s_valid = 1'b1;
    s_data = 32'h5;
    step();
    s_valid = 1'b0;
    chk("mid.reload_addr", 64'(imem_addr), 64'h030);
    chk("mid.reload_sum", 64'(checksum), 64'h5);
    chk_release("mid");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Boot/program-load controller between an external word-stream source and the instruction memory write port.
- Holds the core in reset, writes `cfg_len` words into imem starting at `cfg_base`, and keeps a running checksum.
- After a fixed hold window it releases the core.
- Replaces ad-hoc direct addr/data/valid pokes into imem with a sequenced, checked load.

Parameters:
- IAW, 9, imem word-address width; depth = 2**IAW words
- DW, 32, instruction/data word width
- HOLD_CYCLES, 4, cycles `core_rst_n` stays low after the last write before release (must be ≥1)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  load request pulse; sampled only in IDLE or RUN
- cfg_base  in  IAW  first imem word address; sampled with start
- cfg_len  in  IAW+1  number of words to load (0..2**IAW); sampled with start
- s_valid  in  1  stream word valid
- s_ready  out  1  loader accepts a word this cycle
- s_data  in  DW  stream word
- imem_we  out  1  imem write enable
- imem_addr  out  IAW  imem write word address
- imem_wdata  out  DW  imem write data
- core_rst_n  out  1  active-low reset to core/datapath
- busy  out  1  high in LOAD and RELEASE
- done  out  1  one-cycle pulse on entering RUN
- err  out  1  one-cycle pulse on a rejected start
- checksum  out  DW  wrapping sum of words loaded in the current/last load

Behaviour:
- Reset, asynchronous: state = IDLE.
  - Outputs: `s_ready` = 0, `imem_we` = 0, `imem_addr` = 0, `imem_wdata` = 0, `core_rst_n` = 0, `busy` = 0, `done` = 0, `err` = 0, `checksum` = 0.
  - The core stays in reset until a successful load completes.
- States: IDLE, LOAD, RELEASE, RUN. All outputs are registered except `s_ready`, which is decoded from state (1 only in LOAD with words remaining).
- IDLE/RUN + start:
  - If `cfg_base` + `cfg_len` > 2**IAW, computed at IAW+2 bits with no wrap: pulse `err` next cycle, stay in the current state, no writes.
  - Otherwise latch base, remaining = `cfg_len`; clear `checksum`; drive `core_rst_n` = 0 next cycle.
  - Go to LOAD, or directly to RELEASE if `cfg_len` == 0.
- LOAD:
  - A beat is accepted when `s_valid` && `s_ready`.
  - The cycle after acceptance: `imem_we` = 1, `imem_addr` = base + index, `imem_wdata` = `s_data`, `checksum` += `s_data` mod 2**DW.
  - Fixed one-cycle latency; one write per accepted beat, back-to-back at full rate.
  - No acceptance implies `imem_we` = 0 next cycle; the address is held.
  - On the cycle the last beat is accepted, `s_ready` drops (next cycle); go to RELEASE.
- RELEASE:
  - The hold counter runs HOLD_CYCLES cycles, counting from the cycle after the final write, so the last write completes before release.
  - Then go to RUN; `core_rst_n` = 1 and `done` pulses in the same cycle.
- RUN:
  - `core_rst_n` = 1, `busy` = 0.
  - A valid start re-enters LOAD and reasserts `core_rst_n` = 0 the next cycle.
  - An invalid start only pulses `err`; the core keeps running.
- `start` in LOAD/RELEASE is ignored: no `err`, config not resampled.
- `s_valid` outside LOAD: ignored, `s_ready` = 0.
- Reset mid-LOAD: immediate return to the reset values. Partially written imem contents are undefined; the core stays held.
- Boundary: base = 2**IAW−1, len = 1 is legal; base = 2**IAW−1, len = 2 is `err`. `imem_addr` never wraps.

Decomposition:
- Shared package `boot_pkg`: typedef `boot_state_e` {IDLE, LOAD, RELEASE, RUN}; constant `BOOT_HOLD_DEFAULT` = 4.
- One natural sub-module, `boot_hold_counter`: loadable down-counter with zero flag, used for RELEASE.
- The remaining-word counter stays inline.

Test Plan:
- Basic load: after reset, start with base = 0x010, len = 3; stream 0x00000013, 0x00100093, 0x00208113 with no gaps.
  - Writes at 0x010/0x011/0x012 on consecutive cycles, each one cycle after its accept.
  - `checksum` = 0x003081B9.
  - `core_rst_n` rises and `done` pulses 4 cycles after the last write.
- Backpressure gaps: base = 0, len = 4, with `s_valid` toggling 1,0,0,1,1,0,1.
  - Exactly 4 writes at addresses 0..3 in order; `imem_we` = 0 in gap cycles.
  - `s_ready` = 0 after the 4th accept.
- Zero length: len = 0 → no `imem_we`; RELEASE, then `done` and `core_rst_n` = 1 after 4 cycles; `checksum` = 0.
- Range errors:
  - base = 0x1FF, len = 2 → `err` pulse, state unchanged, no writes.
  - base = 0x1FF, len = 1 → single write at 0x1FF.
- Reload from RUN: start with len = 2 while in RUN.
  - `core_rst_n` = 0 the next cycle and `busy` = 1.
  - `checksum` restarts from 0; a start issued during LOAD is ignored.
- Reset mid-load: assert `rst_n` low after 2 of 5 beats → all outputs at reset values immediately; `core_rst_n` remains 0 after deassertion until a new load completes.
